// File: rtl/trig_capture.sv
// Oscilloscope capture: circular sample buffer, level/slope trigger, frozen frame readout.
// Optional forced trigger after a timeout in WAIT_TRIG when AUTO_TRIG_EN is defined.
module trig_capture #(
   parameter int DW      = 12,
   parameter int DEPTH   = 640,
   parameter int AW      = 10,
   parameter int PRE     = 320,
   parameter int AUTO_TO = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] sample_in,
   input  logic          sample_valid,
   input  logic [DW-1:0] trig_level,
   input  logic          trig_rising,
   input  logic          single,
   input  logic          arm,
   output logic          frame_valid,
   input  logic          frame_ack,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [2:0]    state_o,
   output logic          auto_flag
);

   localparam int POST_N  = DEPTH - PRE - 1;
   localparam int CNT_MAX = (DEPTH > AUTO_TO) ? DEPTH : AUTO_TO;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
   localparam logic [CW-1:0] POST_LAST = CW'(POST_N - 1);
   localparam logic [AW-1:0] WP_LAST   = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   BACK_OFS  = (AW+1)'(DEPTH - PRE);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARM       = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wp_q, wp_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   prev_q, prev_d;
   logic            prev_valid_q, prev_valid_d;
   logic [AW-1:0]   trig_ptr_q, trig_ptr_d;
   logic            frame_valid_q, frame_valid_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;
   logic            we, go_arm, hit, force_trig;
   logic [AW:0]     base_sum, phys_sum;
   logic [AW-1:0]   base, phys;
   logic [DW-1:0]   mem [DEPTH];

`ifdef AUTO_TRIG_EN
   logic auto_q, auto_d;
   assign force_trig = (cnt_q == CW'(AUTO_TO - 1));
   assign auto_flag  = auto_q;
`else
   assign force_trig = 1'b0;
   assign auto_flag  = 1'b0;
`endif

   // prev_valid guarantees the first sample after ARM entry only seeds prev
   assign hit = prev_valid_q &&
                (trig_rising ? (prev_q < trig_level && sample_in >= trig_level)
                             : (prev_q > trig_level && sample_in <= trig_level));

   always_comb begin
      state_d      = state_q;
      wp_d         = wp_q;
      cnt_d        = cnt_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      trig_ptr_d   = trig_ptr_q;
      we           = 1'b0;
      go_arm       = 1'b0;
`ifdef AUTO_TRIG_EN
      auto_d       = auto_q;
`endif
      case (state_q)
         IDLE: begin
            if (!single || arm) go_arm = 1'b1;
         end
         ARM: begin
            if (sample_valid) begin
               we = 1'b1;
               if (cnt_q == PRE_LAST) begin
                  state_d = WAIT_TRIG;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         WAIT_TRIG: begin
            if (sample_valid) begin
               we = 1'b1;
               if (hit || force_trig) begin
                  trig_ptr_d = wp_q;
                  cnt_d      = '0;
                  state_d    = (POST_N == 0) ? DONE : POST;
`ifdef AUTO_TRIG_EN
                  auto_d     = !hit;
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         POST: begin
            if (sample_valid) begin
               we = 1'b1;
               if (cnt_q == POST_LAST) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (frame_ack) begin
               if (single) state_d = IDLE;
               else        go_arm  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // arm restarts from any active state and beats a same-cycle ack or hit
      if (arm && state_q != IDLE) begin
         go_arm = 1'b1;
         we     = 1'b0;
      end

      if (we) begin
         prev_d       = sample_in;
         prev_valid_d = 1'b1;
         wp_d         = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
      end

      if (go_arm) begin
         state_d      = ARM;
         cnt_d        = '0;
         prev_valid_d = 1'b0;
`ifdef AUTO_TRIG_EN
         auto_d       = 1'b0;
`endif
      end

      frame_valid_d = (state_d == DONE);
   end

   // Oldest frame sample sits DEPTH-PRE past the trigger, modulo DEPTH
   always_comb begin
      base_sum  = {1'b0, trig_ptr_q} + BACK_OFS;
      base      = AW'((base_sum >= DEPTH_W) ? base_sum - DEPTH_W : base_sum);
      phys_sum  = {1'b0, base} + {1'b0, rd_addr};
      phys      = AW'((phys_sum >= DEPTH_W) ? phys_sum - DEPTH_W : phys_sum);
      rd_data_d = ({1'b0, rd_addr} >= DEPTH_W) ? '0 : mem[phys];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         wp_q          <= '0;
         cnt_q         <= '0;
         prev_valid_q  <= 1'b0;
         trig_ptr_q    <= '0;
         frame_valid_q <= 1'b0;
         rd_data_q     <= '0;
`ifdef AUTO_TRIG_EN
         auto_q        <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         wp_q          <= wp_d;
         cnt_q         <= cnt_d;
         prev_valid_q  <= prev_valid_d;
         trig_ptr_q    <= trig_ptr_d;
         frame_valid_q <= frame_valid_d;
         rd_data_q     <= rd_data_d;
`ifdef AUTO_TRIG_EN
         auto_q        <= auto_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      prev_q <= prev_d;
      if (we) mem[wp_q] <= sample_in;
   end

   assign frame_valid = frame_valid_q;
   assign rd_data     = rd_data_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture: ramp/step frames, hold, single-shot, re-arm, wrap, reset, auto trigger.
module tb_trig_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic [11:0] trig_level = 12'd2048;
   logic        trig_rising = 1'b1;
   logic        single = 1'b0;
   logic        arm = 1'b0;
   logic        frame_valid;
   logic        frame_ack = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [11:0] rd_data;
   logic [2:0]  state_o;
   logic        auto_flag;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   trig_capture dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .trig_level(trig_level), .trig_rising(trig_rising), .single(single), .arm(arm),
      .frame_valid(frame_valid), .frame_ack(frame_ack), .rd_addr(rd_addr),
      .rd_data(rd_data), .state_o(state_o), .auto_flag(auto_flag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic strobe(input int v);
      sample_in    = v[11:0];
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      repeat (3) tick();
   endtask

   // expected value queued when the address is driven, compared one edge later
   task automatic rd(input string tag, input int a, input int e);
      int ev;
      rd_addr = a[9:0];
      exp_q.push_back(e);
      tick();
      ev = exp_q.pop_front();
      chk(tag, {20'd0, rd_data}, ev);
   endtask

   task automatic pulse_ack();
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   initial begin
      // reset values
      repeat (2) tick();
      chk("rst_state", state_o, 0);
      chk("rst_fv", frame_valid, 0);
      chk("rst_rd", rd_data, 0);
      chk("rst_auto", auto_flag, 0);
      rst = 1'b1;
      tick();
      chk("idle_to_arm", state_o, 1);

      // 1: rising ramp 4*n, trigger at n=512
      for (int n = 0; n < 832; n++) begin
         strobe(4 * n);
         if (n == 319) chk("t1_wait_entry", state_o, 2);
         if (n == 830) chk("t1_fv_early", frame_valid, 0);
      end
      chk("t1_fv", frame_valid, 1);
      chk("t1_done", state_o, 4);
      rd("t1_rd0", 0, 768);
      rd("t1_rd319", 319, 2044);
      rd("t1_rd320", 320, 2048);
      rd("t1_rd639", 639, 3324);
      rd("t6_rd700", 700, 0);

      // 3: hold DONE through 2000 strobes
      for (int n = 0; n < 2000; n++) begin
         strobe(5);
         if (n % 500 == 499) begin
            rd("t3_hold", 320, 2048);
            chk("t3_state", state_o, 4);
         end
      end
      rd("t3_hold0", 0, 768);
      pulse_ack();
      chk("t3_ack_arm", state_o, 1);
      chk("t3_ack_fv", frame_valid, 0);

      // 2: first sample 3000, falling ramp crosses 2048 at k=558
      trig_rising = 1'b0;
      for (int k = 0; k < 878; k++) begin
         strobe((k < 320) ? 3000 : 3000 - 4 * (k - 320));
         if (k == 557) chk("t2_no_early", state_o, 2);
         if (k == 876) chk("t2_fv_early", frame_valid, 0);
      end
      chk("t2_fv", frame_valid, 1);
      rd("t2_rd320", 320, 2048);
      rd("t2_rd319", 319, 2052);
      rd("t2_rd0", 0, 3000);
      rd("t2_rd639", 639, 772);

      // 4: single shot, writes blocked in IDLE, arm mid-POST restarts
      single = 1'b1;
      pulse_ack();
      chk("t4_idle", state_o, 0);
      for (int n = 0; n < 5; n++) strobe(7);
      chk("t4_still_idle", state_o, 0);
      rd("t4_nowrite", 0, 3000);
      trig_rising = 1'b1;
      pulse_arm();
      chk("t4_armed", state_o, 1);
      for (int n = 0; n < 601; n++) strobe(4 * n);
      chk("t4_post", state_o, 3);
      pulse_arm();
      chk("t4_rearm", state_o, 1);
      chk("t4_rearm_fv", frame_valid, 0);
      for (int n = 0; n < 832; n++) begin
         strobe(4 * n);
         if (n == 319) chk("t4_wait_entry", state_o, 2);
         if (n == 830) chk("t4_fv_early", frame_valid, 0);
      end
      chk("t4_fv", frame_valid, 1);
      rd("t4_rd320", 320, 2048);
      rd("t4_rd0", 0, 768);
      pulse_ack();
      chk("t4_ack_idle", state_o, 0);

      // 6: trigger lands at address DEPTH-1, readout wraps
      single = 1'b0;
      tick();
      for (int j = 0; j < 1016; j++) begin
         strobe((j < 696) ? j : 2048 + (j - 696));
         if (j == 695) chk("t6_wait", state_o, 2);
         if (j == 696) chk("t6_post", state_o, 3);
         if (j == 1014) chk("t6_fv_early", frame_valid, 0);
      end
      chk("t6_fv", frame_valid, 1);
      rd("t6_rd0", 0, 376);
      rd("t6_rd319", 319, 695);
      rd("t6_rd320", 320, 2048);
      rd("t6_rd321", 321, 2049);
      rd("t6_rd322", 322, 2050);
      rd("t6_rd639", 639, 2367);
      rd("t6_rd1023", 1023, 0);

      // 6: async reset mid-POST
      pulse_ack();
      chk("t6_ack_arm", state_o, 1);
      for (int n = 0; n < 551; n++) strobe(4 * n);
      chk("t6_in_post", state_o, 3);
      rd_addr = 10'd320;
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_state", state_o, 0);
      chk("t6_rst_fv", frame_valid, 0);
      chk("t6_rst_rd", rd_data, 0);
      chk("t6_rst_auto", auto_flag, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("t5_arm", state_o, 1);

      // 5: constant input never crosses the level
      for (int n = 0; n < 1663; n++) begin
         strobe(100);
`ifdef AUTO_TRIG_EN
         if (n == 1661) chk("t5_fv_early", frame_valid, 0);
`endif
      end
`ifdef AUTO_TRIG_EN
      chk("t5_fv", frame_valid, 1);
      chk("t5_auto", auto_flag, 1);
      rd("t5_rd0", 0, 100);
      rd("t5_rd320", 320, 100);
      rd("t5_rd639", 639, 100);
      pulse_ack();
      chk("t5_ack_arm", state_o, 1);
      chk("t5_auto_clr", auto_flag, 0);
`else
      chk("t5_no_fv", frame_valid, 0);
      chk("t5_wait", state_o, 2);
      chk("t5_no_auto", auto_flag, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
